// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encodings, opcodes and datapath select codes
package mips_ctrl_pkg;
    typedef enum logic [3:0] {
        S_RESET   = 4'b0000,
        S_FETCH   = 4'b0001,
        S_DECODE  = 4'b0101,
        S_MEMADR  = 4'b0110,
        S_LBRD    = 4'b0111,
        S_LBWR    = 4'b1000,
        S_SBWR    = 4'b1001,
        S_RTYPEEX = 4'b1010,
        S_RTYPEWR = 4'b1011,
        S_BEQEX   = 4'b1100,
        S_JEX     = 4'b1101,
        S_ADDIWR  = 4'b1110,
        S_BNEEX   = 4'b1111
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b100100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b100010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_INC    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRTGT = 2'b11;

    // Beat counter width, never narrower than one bit
    function automatic int beat_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mips_mc_controller_p_if.sv
// mips_mc_controller_p_if: controller-to-datapath bundle; master is the controller
interface mips_mc_controller_p_if
    import mips_ctrl_pkg::*;
#(
    parameter int FETCH_BEATS = 4
);
    localparam int BEAT_W = beat_width(FETCH_BEATS);

    logic [5:0]             op;
    logic                   zero;
    logic                   mem_ready;
    logic                   memread;
    logic                   memwrite;
    logic                   alusrca;
    logic                   memtoreg;
    logic                   iord;
    logic                   pcen;
    logic                   regwrite;
    logic                   regdst;
    logic [1:0]             pcsource;
    logic [1:0]             alusrcb;
    logic [1:0]             aluop;
    logic [FETCH_BEATS-1:0] irwrite;
    logic [3:0]             state;
    logic [BEAT_W-1:0]      beat_cnt;
    logic                   illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst,
               pcsource, alusrcb, aluop, irwrite, state, beat_cnt, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst,
               pcsource, alusrcb, aluop, irwrite, state, beat_cnt, illegal_op
    );
endinterface

// File: rtl/mips_fetch_seq.sv
// mips_fetch_seq: fetch beat counter and one-hot instruction-register byte enable
module mips_fetch_seq
    import mips_ctrl_pkg::*;
#(
    parameter int FETCH_BEATS = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_fetch,
    input  logic                                ready,
    output logic [beat_width(FETCH_BEATS)-1:0]  beat_cnt,
    output logic [FETCH_BEATS-1:0]              irwrite,
    output logic                                last_beat
);
    localparam int BEAT_W = beat_width(FETCH_BEATS);
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(FETCH_BEATS - 1);

    assign last_beat = (beat_cnt == LAST);
    assign irwrite   = (in_fetch && ready) ? (FETCH_BEATS'(1) << beat_cnt) : '0;

    // Count accepted beats; zero outside FETCH and after the final beat so every fetch starts at byte 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beat_cnt <= '0;
        else        beat_cnt <= (!in_fetch || (ready && last_beat)) ? '0 : beat_cnt + BEAT_W'(ready);
    end
endmodule

// File: rtl/mips_mc_controller_p.sv
// mips_mc_controller_p: multicycle TinyMIPS control FSM with parametrised fetch and memory handshake
module mips_mc_controller_p
    import mips_ctrl_pkg::*;
#(
    parameter int FETCH_BEATS   = 4,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_mc_controller_p_if.master bus
);
    state_t state, next_state;
    logic   illegal, set_illegal, ready, in_fetch, last_beat;

    assign ready          = USE_MEM_READY ? bus.mem_ready : 1'b1;
    assign in_fetch       = (state == S_FETCH);
    assign bus.state      = state;
    assign bus.illegal_op = illegal;

    mips_fetch_seq #(.FETCH_BEATS(FETCH_BEATS)) u_fetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_fetch  (in_fetch),
        .ready     (ready),
        .beat_cnt  (bus.beat_cnt),
        .irwrite   (bus.irwrite),
        .last_beat (last_beat)
    );

    // State register and sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RESET;
            illegal <= 1'b0;
        end else begin
            state   <= next_state;
            illegal <= illegal | set_illegal;
        end
    end

    // Next state and Moore outputs; only pcen and FETCH handshake depend on inputs
    always_comb begin
        next_state   = state;
        set_illegal  = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.memtoreg = 1'b0;
        bus.iord     = 1'b0;
        bus.pcen     = 1'b0;
        bus.regwrite = 1'b0;
        bus.regdst   = 1'b0;
        bus.pcsource = PCSRC_INC;
        bus.alusrcb  = SRCB_REG;
        bus.aluop    = ALUOP_ADD;
        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                bus.memread = 1'b1;
                bus.alusrcb = SRCB_FOUR;
                bus.pcen    = ready;
                if (ready && last_beat) next_state = S_DECODE;
            end
            S_DECODE: begin
                bus.alusrcb = SRCB_BRTGT;
                case (bus.op)
                    OP_LB, OP_SB, OP_ADDI: next_state = S_MEMADR;
                    OP_RTYPE:              next_state = S_RTYPEEX;
                    OP_BEQ:                next_state = S_BEQEX;
                    OP_BNE:                next_state = S_BNEEX;
                    OP_J:                  next_state = S_JEX;
                    default: begin
                        next_state  = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                next_state  = (bus.op == OP_LB)   ? S_LBRD :
                              (bus.op == OP_SB)   ? S_SBWR :
                              (bus.op == OP_ADDI) ? S_ADDIWR : S_FETCH;
            end
            S_LBRD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
                if (ready) next_state = S_LBWR;
            end
            S_LBWR: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
                next_state   = S_FETCH;
            end
            S_SBWR: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
                if (ready) next_state = S_FETCH;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = ALUOP_FUNCT;
                next_state  = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
                next_state   = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                bus.alusrca  = 1'b1;
                bus.aluop    = ALUOP_SUB;
                bus.pcsource = PCSRC_BRANCH;
                bus.pcen     = (state == S_BEQEX) ? bus.zero : ~bus.zero;
                next_state   = S_FETCH;
            end
            S_JEX: begin
                bus.pcsource = PCSRC_JUMP;
                bus.pcen     = 1'b1;
                next_state   = S_FETCH;
            end
            S_ADDIWR: begin
                bus.regwrite = 1'b1;
                next_state   = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_mips_mc_controller_p.sv
// tb_mips_mc_controller_p: vector table plus scoreboard for the multicycle controller
module tb_mips_mc_controller_p;
    localparam logic [5:0] LB   = 6'b100000;
    localparam logic [5:0] SB   = 6'b101000;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b100100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] J    = 6'b100010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ILL  = 6'b111111;

    // exp = {state, beat_cnt, irwrite, memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst, pcsource, alusrcb, aluop, illegal_op}
    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [24:0] exp;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [24:0] sb_q[$];
    string       nm_q[$];
    vec_t        tbl[$];

    mips_mc_controller_p_if #(.FETCH_BEATS(4)) bus4();
    mips_mc_controller_p_if #(.FETCH_BEATS(1)) bus1();
    mips_mc_controller_p_if #(.FETCH_BEATS(8)) bus8();

    mips_mc_controller_p #(.FETCH_BEATS(4), .USE_MEM_READY(1'b1)) dut4 (.clk(clk), .rst_n(rst_n),  .bus(bus4));
    mips_mc_controller_p #(.FETCH_BEATS(1), .USE_MEM_READY(1'b1)) dut1 (.clk(clk), .rst_n(rst2_n), .bus(bus1));
    mips_mc_controller_p #(.FETCH_BEATS(8), .USE_MEM_READY(1'b1)) dut8 (.clk(clk), .rst_n(rst2_n), .bus(bus8));

    always #5 clk = ~clk;

    logic [24:0] act4;
    assign act4 = {bus4.state, bus4.beat_cnt, bus4.irwrite, bus4.memread, bus4.memwrite, bus4.alusrca,
                   bus4.memtoreg, bus4.iord, bus4.pcen, bus4.regwrite, bus4.regdst,
                   bus4.pcsource, bus4.alusrcb, bus4.aluop, bus4.illegal_op};

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic vec_t v(input string nm, input logic [5:0] op, input logic z, input logic r,
                               input logic [3:0] st, input logic [1:0] bc, input logic [3:0] ir,
                               input logic [7:0] ctl, input logic [5:0] sel, input logic ill);
        vec_t x;
        x.op   = op;
        x.zero = z;
        x.rdy  = r;
        x.exp  = {st, bc, ir, ctl, sel, ill};
        x.name = nm;
        return x;
    endfunction

    // A FETCH cycle: memread, alusrcb=01; byte enable and pcen only when ready
    function automatic vec_t f(input string nm, input logic [5:0] op, input logic [1:0] bc,
                               input logic r, input logic ill);
        return v(nm, op, 1'b0, r, 4'h1, bc, r ? (4'b0001 << bc) : 4'b0000,
                 r ? 8'b1000_0100 : 8'b1000_0000, 6'b000100, ill);
    endfunction

    task automatic add_fetch(input string nm, input logic [5:0] op, input logic ill);
        for (int k = 0; k < 4; k++) tbl.push_back(f($sformatf("%s_f%0d", nm, k), op, 2'(k), 1'b1, ill));
        tbl.push_back(v({nm, "_dec"}, op, 1'b0, 1'b1, 4'h5, 2'd0, 4'h0, 8'h00, 6'b001100, ill));
    endtask

    task automatic drive(input vec_t x);
        bus4.op        = x.op;
        bus4.zero      = x.zero;
        bus4.mem_ready = x.rdy;
        sb_q.push_back(x.exp);
        nm_q.push_back(x.name);
    endtask

    task automatic sample();
        logic [24:0] e;
        string       n;
        #2;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            n = nm_q.pop_front();
            chk(n, 32'(act4), 32'(e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t z;
        int   n1, n8;
        bit   l1, l8, d1, d8;
        bus4.op = LB; bus4.zero = 1'b0; bus4.mem_ready = 1'b1;
        bus1.op = J;  bus1.zero = 1'b0; bus1.mem_ready = 1'b1;
        bus8.op = J;  bus8.zero = 1'b0; bus8.mem_ready = 1'b1;

        add_fetch("lb", LB, 1'b0);
        tbl.push_back(v("lb_adr", LB, 1'b0, 1'b1, 4'h6, 2'd0, 4'h0, 8'b0010_0000, 6'b001000, 1'b0));
        tbl.push_back(v("lb_rd",  J,  1'b0, 1'b1, 4'h7, 2'd0, 4'h0, 8'b1000_1000, 6'b000000, 1'b0));
        tbl.push_back(v("lb_wr",  J,  1'b0, 1'b1, 4'h8, 2'd0, 4'h0, 8'b0001_0010, 6'b000000, 1'b0));
        tbl.push_back(f("stall_b0",    ADDI, 2'd0, 1'b1, 1'b0));
        tbl.push_back(f("stall_b1",    ADDI, 2'd1, 1'b1, 1'b0));
        tbl.push_back(f("stall_hold0", ADDI, 2'd2, 1'b0, 1'b0));
        tbl.push_back(f("stall_hold1", ADDI, 2'd2, 1'b0, 1'b0));
        tbl.push_back(f("stall_b2",    ADDI, 2'd2, 1'b1, 1'b0));
        tbl.push_back(f("stall_b3",    ADDI, 2'd3, 1'b1, 1'b0));
        tbl.push_back(v("addi_dec", ADDI, 1'b0, 1'b1, 4'h5, 2'd0, 4'h0, 8'h00, 6'b001100, 1'b0));
        tbl.push_back(v("addi_adr", ADDI, 1'b0, 1'b1, 4'h6, 2'd0, 4'h0, 8'b0010_0000, 6'b001000, 1'b0));
        tbl.push_back(v("addi_wr",  ADDI, 1'b0, 1'b1, 4'he, 2'd0, 4'h0, 8'b0000_0010, 6'b000000, 1'b0));
        add_fetch("beq1", BEQ, 1'b0);
        tbl.push_back(v("beq_taken", BEQ, 1'b1, 1'b1, 4'hc, 2'd0, 4'h0, 8'b0010_0100, 6'b010001, 1'b0));
        add_fetch("beq0", BEQ, 1'b0);
        tbl.push_back(v("beq_not",   BEQ, 1'b0, 1'b1, 4'hc, 2'd0, 4'h0, 8'b0010_0000, 6'b010001, 1'b0));
        add_fetch("bne0", BNE, 1'b0);
        tbl.push_back(v("bne_taken", BNE, 1'b0, 1'b1, 4'hf, 2'd0, 4'h0, 8'b0010_0100, 6'b010001, 1'b0));
        add_fetch("bne1", BNE, 1'b0);
        tbl.push_back(v("bne_not",   BNE, 1'b1, 1'b1, 4'hf, 2'd0, 4'h0, 8'b0010_0000, 6'b010001, 1'b0));
        add_fetch("j", J, 1'b0);
        tbl.push_back(v("j_ex", J, 1'b0, 1'b1, 4'hd, 2'd0, 4'h0, 8'b0000_0100, 6'b100000, 1'b0));
        add_fetch("ill", ILL, 1'b0);
        add_fetch("rt", RT, 1'b1);
        tbl.push_back(v("rt_ex", RT, 1'b0, 1'b1, 4'ha, 2'd0, 4'h0, 8'b0010_0000, 6'b000010, 1'b1));
        tbl.push_back(v("rt_wr", RT, 1'b0, 1'b1, 4'hb, 2'd0, 4'h0, 8'b0000_0011, 6'b000000, 1'b1));
        add_fetch("sb", SB, 1'b1);
        tbl.push_back(v("sb_adr",   SB, 1'b0, 1'b1, 4'h6, 2'd0, 4'h0, 8'b0010_0000, 6'b001000, 1'b1));
        tbl.push_back(v("sb_hold0", SB, 1'b0, 1'b0, 4'h9, 2'd0, 4'h0, 8'b0100_1000, 6'b000000, 1'b1));
        tbl.push_back(v("sb_hold1", SB, 1'b0, 1'b0, 4'h9, 2'd0, 4'h0, 8'b0100_1000, 6'b000000, 1'b1));

        z = v("rst_hold", LB, 1'b0, 1'b1, 4'h0, 2'd0, 4'h0, 8'h00, 6'b000000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(z);
            sample();
        end
        @(negedge clk);
        rst_n = 1'b1;
        z.name = "rst_release";
        drive(z);
        sample();

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            sample();
        end

        z = v("rst_mid_sbwr", SB, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 8'h00, 6'b000000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(z);
        sample();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(z);
            sample();
        end
        @(negedge clk);
        rst_n = 1'b1;
        z.name = "rst2_release";
        drive(z);
        sample();
        @(negedge clk);
        drive(f("rst2_f0_stall", SB, 2'd0, 1'b0, 1'b0));
        sample();
        @(negedge clk);
        drive(f("rst2_f0", SB, 2'd0, 1'b1, 1'b0));
        sample();

        @(negedge clk);
        #2;
        chk("fb8_rst_state", 32'(bus8.state), 32'h0);
        chk("fb8_rst_ir", 32'(bus8.irwrite), 32'h0);
        rst2_n = 1'b1;
        n1 = 0; n8 = 0; l1 = 0; l8 = 0; d1 = 0; d8 = 0;
        for (int i = 0; i < 30 && !(d1 && d8); i++) begin
            @(negedge clk);
            #2;
            if (!d1) begin
                if (bus1.state == 4'h1 && l1) d1 = 1;
                else begin
                    if (bus1.state != 4'h1) l1 = 1;
                    if (bus1.state == 4'h1) chk("fb1_ir", 32'(bus1.irwrite), 32'h1);
                    if (bus1.state == 4'hd) chk("fb1_jex_pcen", 32'(bus1.pcen), 32'h1);
                    n1++;
                end
            end
            if (!d8) begin
                if (bus8.state == 4'h1 && l8) d8 = 1;
                else begin
                    if (bus8.state != 4'h1) l8 = 1;
                    if (bus8.state == 4'h1) chk($sformatf("fb8_ir_b%0d", n8), 32'(bus8.irwrite), (n8 < 8) ? (32'd1 << n8) : 32'd0);
                    if (bus8.state == 4'hd) chk("fb8_jex_pcen", 32'(bus8.pcen), 32'h1);
                    n8++;
                end
            end
        end
        chk("fb1_done", 32'(d1), 32'h1);
        chk("fb8_done", 32'(d8), 32'h1);
        chk("fb1_j_cycles", 32'(n1), 32'd3);
        chk("fb8_j_cycles", 32'(n8), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_mc_controller_p.md
Name: mips_mc_controller_p

Overview:
- Parametrised multicycle control unit for the TinyMIPS datapath.
- Fetch beat count is set by a parameter instead of being fixed at four. Adds a memory ready/wait handshake, a BNE instruction, an explicit reset state and a sticky illegal-opcode flag.
- Drives every datapath enable and mux select from a single Moore FSM plus a beat counter. Branch and ready gating are the only combinational terms on outputs.

Parameters:
- FETCH_BEATS, 4, instruction-register bytes per instruction; legal range 1..8; sets the width of irwrite.
- USE_MEM_READY, 1, when 1 memory states wait on mem_ready; when 0 mem_ready is ignored and treated as 1.
- BEAT_W, derived as max(1, clog2(FETCH_BEATS)), width of beat_cnt; not overridable.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous reset, active-low.
- op, in, 6: opcode field of the instruction register.
- zero, in, 1: ALU zero flag.
- mem_ready, in, 1: memory has completed the current read or write this cycle.
- memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst, out, 1 each: datapath controls.
- pcsource, alusrcb, aluop, out, 2 each: mux selects and ALU operation class.
- irwrite, out, FETCH_BEATS: one-hot instruction-register byte enable.
- state, out, 4: current state encoding, for debug.
- beat_cnt, out, BEAT_W: current fetch beat.
- illegal_op, out, 1: sticky flag set when an unknown opcode is decoded.

Behaviour:
- State encodings (shared package):
  - RESET=0000, FETCH=0001, DECODE=0101, MEMADR=0110, LBRD=0111, LBWR=1000
  - SBWR=1001, RTYPEEX=1010, RTYPEWR=1011, BEQEX=1100, JEX=1101, ADDIWR=1110, BNEEX=1111
- Opcodes: LB=100000, SB=101000, RTYPE=000000, BEQ=100100, BNE=000101, J=100010, ADDI=001000.
- While rst_n=0:
  - state=RESET, beat_cnt=0, illegal_op=0.
  - All control outputs 0, including irwrite.
  - Reset is honoured mid-fetch and mid-memory access; no partial completion.
- RESET: all outputs 0; goes to FETCH with beat_cnt=0 on the first clock after release.
- FETCH:
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - When mem_ready=1 (effective): irwrite[beat_cnt]=1 and pcen=1.
  - If beat_cnt=FETCH_BEATS-1, go to DECODE; otherwise beat_cnt increments.
  - When mem_ready=0: hold state and beat_cnt; irwrite=0, pcen=0, memread stays 1.
  - Beat k always writes byte k.
  - FETCH_BEATS=1: a single beat, then DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (precomputes branch target).
  - Next state by op: LB/SB/ADDI -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; BNE -> BNEEX; J -> JEX.
  - Any other op: illegal_op<=1, then FETCH with beat_cnt=0.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state: LB -> LBRD, SB -> SBWR, ADDI -> ADDIWR.
- LBRD: memread=1, iord=1. Goes to LBWR when mem_ready=1, otherwise holds.
- LBWR: regwrite=1, memtoreg=1, regdst=0. Then FETCH.
- SBWR: memwrite=1, iord=1. Goes to FETCH when mem_ready=1, otherwise holds with memwrite still 1.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Then RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1, memtoreg=0. Then FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pcen=zero. Then FETCH.
- BNEEX: same as BEQEX except pcen=~zero. Then FETCH.
- JEX: pcsource=10, pcen=1. Then FETCH.
- ADDIWR: regwrite=1, regdst=0, memtoreg=0. Then FETCH.
- Output defaults: every output not listed for a state is 0.
- beat_cnt is reset to 0 on every entry to FETCH.
- op is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- illegal_op is cleared only by reset.
- Cycle counts with ready always 1:
  - LB: FETCH_BEATS+4
  - SB, RTYPE, ADDI: FETCH_BEATS+3
  - BEQ, BNE, J: FETCH_BEATS+2

Decomposition:
- Package mips_ctrl_pkg holds the state encodings, opcode constants, and the ALUOP/PCSRC/ALUSRCB code constants.
- One sub-module, mips_fetch_seq: beat counter plus irwrite one-hot decoder, parametrised by FETCH_BEATS and gated by ready.
- FSM and output decode live in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release mid-SBWR stall -> all outputs 0 during reset, state=0000, then 0001 on the next edge with beat_cnt=0.
- FETCH_BEATS=4, mem_ready=1, op=LB:
  - irwrite=0001,0010,0100,1000 on consecutive cycles with pcen=1 each cycle.
  - Then states 0101,0110,0111,1000; 8 cycles total.
- Fetch stall: mem_ready=0 for 2 cycles during beat 2 -> irwrite=0, pcen=0, memread=1 and beat_cnt=2 held; resumes with irwrite=0100.
- Branches:
  - BEQ with zero=1: pcen=1, pcsource=01.
  - BEQ with zero=0: pcen=0.
  - BNE with zero=0: pcen=1 (state 1111).
- Illegal and RTYPE:
  - op=111111 -> illegal_op=1, returns to FETCH.
  - A following RTYPE -> aluop=10, then regdst=1, regwrite=1; illegal_op stays 1.
- FETCH_BEATS=1 and FETCH_BEATS=8:
  - J completes in 3 and 10 cycles respectively.
  - irwrite width is 1 and 8 respectively, with the correct one-hot sequence.
